uut_port_arbiter: RTL and testbench
===================================

// Module: uut_port_arbiter
// PURPOSE
//  Shares one UUT memory port (read addr/data channel + write channel) between REQUESTERS
//  masters. Registered grant; one transfer per arbitration, round-robin by default.
//  Read responses return in order and are routed back via an outstanding-ID FIFO.
//  Sits between per-requester traffic generators and the single UUT instance in the bench/top.
// PARAMETERS
//  REQUESTERS   3    number of masters (from transaction_pkg)
//  ADDR_WIDTH   16   address width
//  DATA_WIDTH   16   data width
//  RD_OUTST     4    max outstanding reads (ID FIFO depth, power of 2)
// PORTS  (ID_W = $clog2(REQUESTERS))
//  clk        in   1                 clock, all logic on posedge
//  reset_p    in   1                 asynchronous, active-high reset
//  s_r_addr   in   [REQ][ADDR_W]     per-requester read address
//  s_r_avalid in   [REQ]             read address valid
//  s_r_aready out  [REQ]             read address accepted
//  s_r_dvalid out  [REQ]             read data valid (1-cycle pulse)
//  s_r_data   out  [REQ][DATA_W]     read data (all requesters see m_r_data)
//  s_w_addr   in   [REQ][ADDR_W]     write address
//  s_w_data   in   [REQ][DATA_W]     write data
//  s_w_valid  in   [REQ]             write valid
//  s_w_ready  out  [REQ]             write accepted
//  m_r_addr/m_r_avalid  out  ADDR_W/1     to UUT read address channel
//  m_r_aready           in   1            UUT read address accept
//  m_r_dvalid/m_r_data  in   1/DATA_W     UUT read response (no backpressure)
//  m_w_addr/m_w_data/m_w_valid out ADDR_W/DATA_W/1; m_w_ready in 1
//  grant_id   out  ID_W              current/last granted requester
//  err_rsp    out  1                 sticky: m_r_dvalid with ID FIFO empty
// BEHAVIOUR
//  - Reset: FSM=IDLE, rr pointer=REQUESTERS-1, FIFO empty, grant_id=0, err_rsp=0,
//    all valid/ready/dvalid outputs 0. Reset mid-transfer aborts it; no handshake completes.
//  - FSM IDLE -> GNT_WR | GNT_RD -> IDLE. IDLE: req[i] = s_w_valid[i] | (s_r_avalid[i] & ~fifo_full).
//    Winner = first i with req set, searching from ptr+1 mod REQUESTERS; registered into grant_id.
//    Winner with both valid: write first (GNT_WR). No req: stay IDLE.
//  - GNT_WR: m_w_* = s_w_*[grant_id] (combinational mux); s_w_ready[grant_id] = m_w_ready.
//    On m_w_valid & m_w_ready: ptr <= grant_id, -> IDLE.
//  - GNT_RD: m_r_addr/avalid muxed likewise; s_r_aready[grant_id] = m_r_aready.
//    On handshake: push grant_id into ID FIFO, ptr <= grant_id, -> IDLE.
//  - Throughput: peak 1 transfer per 2 cycles (IDLE arbitration bubble); min latency
//    valid->ready = 1 cycle when UUT ready is held high.
//  - Requesters hold valid/addr/data until ready; a dropped valid while granted is not
//    recovered (grant held, mux passes the low valid) - bench checks it never happens.
//  - Read return: on m_r_dvalid pop FIFO head h; s_r_dvalid[h]=1 same cycle (0 latency);
//    s_r_data[*]=m_r_data. dvalid with FIFO empty: no s_r_dvalid, err_rsp<=1 until reset.
//  - Push and pop in same cycle legal at any level; fifo_full blocks new read grants only,
//    writes still arbitrate. FIFO pointers wrap mod RD_OUTST, count is ID_W-independent.
//  - Ungranted requesters: aready/ready = 0.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 highest, rr pointer unused
//    (starvation allowed). Undefined (default): round-robin as above.
// STRUCTURE
//  transaction_pkg: REQUESTERS, ADDR_WIDTH, DATA_WIDTH, ID_W localparam,
//    typedef enum logic[1:0] {ARB_IDLE, ARB_GNT_RD, ARB_GNT_WR} type_arb_state.
//  Sub-module arb_id_fifo (WIDTH=ID_W, DEPTH=RD_OUTST): push/pop/head/full/empty, async reset.
// TESTING
//  1 All 3 assert s_w_valid continuously, m_w_ready=1 -> grants 0,1,2,0,... each write 2 cycles apart.
//  2 Req1 read 0x0010, UUT returns 0xBEEF 3 cycles later -> s_r_dvalid[1] pulse, s_r_data=0xBEEF.
//  3 5 reads, m_r_dvalid held 0 -> 4 accepted, 5th aready stays 0; a write is still granted.
//  4 Req2 both read+write valid -> write handshake first, then read in next grant.
//  5 m_r_dvalid with no outstanding read -> err_rsp=1 sticky; reset_p pulse mid-GNT_WR -> all outputs 0.
//  6 ARB_FIXED_PRIO_EN, req0 and req2 continuous -> req2 never granted.

Source files
------------

// File: rtl/transaction_pkg.sv
// Shared sizing constants and arbiter state type for the UUT port arbiter.
package transaction_pkg;

  localparam int unsigned REQUESTERS = 3;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned RD_OUTST   = 4;
  localparam int unsigned ID_W       = $clog2(REQUESTERS);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_RD,
    ARB_GNT_WR
  } type_arb_state;

endpackage

// File: rtl/arb_id_fifo.sv
// Small FIFO holding the requester ID of every outstanding read, oldest at head.
module arb_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push while full is still legal.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= inc_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= inc_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uut_port_arbiter.sv
// Shares one UUT read/write port between several masters, one transfer per grant.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module uut_port_arbiter #(
  parameter int unsigned REQUESTERS = transaction_pkg::REQUESTERS,
  parameter int unsigned ADDR_WIDTH = transaction_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = transaction_pkg::DATA_WIDTH,
  parameter int unsigned RD_OUTST   = transaction_pkg::RD_OUTST
) (
  input  logic                                  clk,
  input  logic                                  reset_p,
  input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] s_r_addr,
  input  logic [REQUESTERS-1:0]                 s_r_avalid,
  output logic [REQUESTERS-1:0]                 s_r_aready,
  output logic [REQUESTERS-1:0]                 s_r_dvalid,
  output logic [REQUESTERS-1:0][DATA_WIDTH-1:0] s_r_data,
  input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] s_w_addr,
  input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] s_w_data,
  input  logic [REQUESTERS-1:0]                 s_w_valid,
  output logic [REQUESTERS-1:0]                 s_w_ready,
  output logic [ADDR_WIDTH-1:0]                 m_r_addr,
  output logic                                  m_r_avalid,
  input  logic                                  m_r_aready,
  input  logic                                  m_r_dvalid,
  input  logic [DATA_WIDTH-1:0]                 m_r_data,
  output logic [ADDR_WIDTH-1:0]                 m_w_addr,
  output logic [DATA_WIDTH-1:0]                 m_w_data,
  output logic                                  m_w_valid,
  input  logic                                  m_w_ready,
  output logic [$clog2(REQUESTERS)-1:0]         grant_id,
  output logic                                  err_rsp
);

  localparam int unsigned ID_W = $clog2(REQUESTERS);
  import transaction_pkg::*;

  type_arb_state   state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] winner;
  logic            found;
  logic [REQUESTERS-1:0] req;
  logic            err_q;
  logic            fifo_push, fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_head;
  int unsigned     idx;

  // Arbitration and state sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    winner  = grant_q;
    idx     = 0;
    req     = s_w_valid | (s_r_avalid & {REQUESTERS{~fifo_full}});
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < int'(REQUESTERS); i++) begin
      if (req[i] && !found) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
`else
    for (int k = 1; k <= int'(REQUESTERS); k++) begin
      idx = (int'(ptr_q) + k) % REQUESTERS;
      if (req[idx] && !found) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = s_w_valid[winner] ? ARB_GNT_WR : ARB_GNT_RD;
        end
      end
      ARB_GNT_WR: begin
        if (s_w_valid[grant_q] && m_w_ready) begin
          ptr_d   = grant_q;
          state_d = ARB_IDLE;
        end
      end
      ARB_GNT_RD: begin
        if (s_r_avalid[grant_q] && m_r_aready) begin
          ptr_d   = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Port muxing towards the UUT and ready routing back to the granted master.
  always_comb begin
    m_w_addr   = s_w_addr[grant_q];
    m_w_data   = s_w_data[grant_q];
    m_w_valid  = 1'b0;
    s_w_ready  = '0;
    m_r_addr   = s_r_addr[grant_q];
    m_r_avalid = 1'b0;
    s_r_aready = '0;
    if (state_q == ARB_GNT_WR) begin
      m_w_valid          = s_w_valid[grant_q];
      s_w_ready[grant_q] = m_w_ready;
    end
    if (state_q == ARB_GNT_RD) begin
      m_r_avalid          = s_r_avalid[grant_q];
      s_r_aready[grant_q] = m_r_aready;
    end
  end

  // Responses go to the oldest outstanding reader in the same cycle.
  always_comb begin
    s_r_dvalid = '0;
    if (m_r_dvalid && !fifo_empty) s_r_dvalid[fifo_head] = 1'b1;
  end

  assign s_r_data  = {REQUESTERS{m_r_data}};
  assign fifo_push = m_r_avalid & m_r_aready;
  assign grant_id  = grant_q;
  assign err_rsp   = err_q;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= ID_W'(REQUESTERS - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_q | (m_r_dvalid & fifo_empty);
    end
  end

  arb_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (RD_OUTST)
  ) u_id_fifo (
    .clk       (clk),
    .reset_p   (reset_p),
    .push      (fifo_push),
    .push_data (grant_q),
    .pop       (m_r_dvalid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uut_port_arbiter.sv
// Scoreboard bench for uut_port_arbiter: directed traffic, queued expectations.
module tb_uut_port_arbiter;
  import transaction_pkg::*;

  logic clk = 1'b0;
  logic reset_p;
  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] s_r_addr, s_w_addr;
  logic [REQUESTERS-1:0][DATA_WIDTH-1:0] s_r_data, s_w_data;
  logic [REQUESTERS-1:0] s_r_avalid, s_r_aready, s_r_dvalid, s_w_valid, s_w_ready;
  logic [ADDR_WIDTH-1:0] m_r_addr, m_w_addr;
  logic [DATA_WIDTH-1:0] m_r_data, m_w_data;
  logic m_r_avalid, m_r_aready, m_r_dvalid, m_w_valid, m_w_ready, err_rsp;
  logic [ID_W-1:0] grant_id;

  typedef struct packed {
    logic                  wr;
    logic [ID_W-1:0]       id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } gnt_t;
  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int hs_cycle = 0;

`ifdef ARB_FIXED_PRIO_EN
  int t1_ids [6] = '{0, 0, 0, 0, 0, 0};
  int t3_ids [4] = '{0, 0, 0, 0};
  int t6_ids [4] = '{0, 0, 0, 0};
`else
  int t1_ids [6] = '{0, 1, 2, 0, 1, 2};
  int t3_ids [4] = '{2, 0, 1, 2};
  int t6_ids [4] = '{2, 0, 2, 0};
`endif

  always #5 clk = ~clk;

  uut_port_arbiter #(
    .REQUESTERS (REQUESTERS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_OUTST   (RD_OUTST)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .s_r_addr   (s_r_addr),
    .s_r_avalid (s_r_avalid),
    .s_r_aready (s_r_aready),
    .s_r_dvalid (s_r_dvalid),
    .s_r_data   (s_r_data),
    .s_w_addr   (s_w_addr),
    .s_w_data   (s_w_data),
    .s_w_valid  (s_w_valid),
    .s_w_ready  (s_w_ready),
    .m_r_addr   (m_r_addr),
    .m_r_avalid (m_r_avalid),
    .m_r_aready (m_r_aready),
    .m_r_dvalid (m_r_dvalid),
    .m_r_data   (m_r_data),
    .m_w_addr   (m_w_addr),
    .m_w_data   (m_w_data),
    .m_w_valid  (m_w_valid),
    .m_w_ready  (m_w_ready),
    .grant_id   (grant_id),
    .err_rsp    (err_rsp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic gnt_t mk_g(input logic wr, input int id, input logic [ADDR_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] d);
    gnt_t g;
    g.wr   = wr;
    g.id   = ID_W'(id);
    g.addr = a;
    g.data = d;
    return g;
  endfunction

  function automatic rsp_t mk_r(input int id, input logic [DATA_WIDTH-1:0] d);
    rsp_t r;
    r.id   = ID_W'(id);
    r.data = d;
    return r;
  endfunction

  // Monitor: every handshake or response the DUT presents is matched to the queue head.
  always @(negedge clk) begin : mon
    gnt_t g;
    rsp_t r;
    cycle++;
    if (!reset_p) begin
      if (m_w_valid && m_w_ready) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected write: actual id %0d addr 0x%0h, required none",
                   grant_id, m_w_addr);
        end else begin
          g = gq.pop_front();
          check("write expected", 32'(1), 32'(g.wr));
          check("write grant_id", 32'(grant_id), 32'(g.id));
          check("write addr", 32'(m_w_addr), 32'(g.addr));
          check("write data", 32'(m_w_data), 32'(g.data));
          check("write s_w_ready", 32'(s_w_ready), 32'(1) << g.id);
        end
      end
      if (m_r_avalid && m_r_aready) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected read: actual id %0d addr 0x%0h, required none",
                   grant_id, m_r_addr);
        end else begin
          g = gq.pop_front();
          check("read expected", 32'(0), 32'(g.wr));
          check("read grant_id", 32'(grant_id), 32'(g.id));
          check("read addr", 32'(m_r_addr), 32'(g.addr));
          check("read s_r_aready", 32'(s_r_aready), 32'(1) << g.id);
        end
      end
      if (s_r_dvalid != '0) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected response: actual s_r_dvalid 0x%0h, required 0", s_r_dvalid);
        end else begin
          r = rq.pop_front();
          check("resp s_r_dvalid", 32'(s_r_dvalid), 32'(1) << r.id);
          check("resp data", 32'(s_r_data[r.id]), 32'(r.data));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_w_hs(input string name);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (m_w_valid && m_w_ready) break;
      if (++n > 100) begin
        checks++;
        errors++;
        $display("FAIL %s: actual timeout, required write handshake", name);
        break;
      end
    end
    hs_cycle = cycle;
    tick(1);
  endtask

  task automatic wait_r_hs(input string name);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (m_r_avalid && m_r_aready) break;
      if (++n > 100) begin
        checks++;
        errors++;
        $display("FAIL %s: actual timeout, required read handshake", name);
        break;
      end
    end
    tick(1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && (gq.size() != 0 || rq.size() != 0); i++) @(posedge clk);
    #1;
    check(name, 32'(gq.size() + rq.size()), 32'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout, required end of test");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int prev;
    reset_p    = 1'b1;
    s_r_addr   = '0;
    s_w_addr   = '0;
    s_w_data   = '0;
    s_r_avalid = '0;
    s_w_valid  = '0;
    m_r_aready = 1'b1;
    m_w_ready  = 1'b1;
    m_r_dvalid = 1'b0;
    m_r_data   = '0;
    for (int i = 0; i < int'(REQUESTERS); i++) begin
      s_w_addr[i] = ADDR_WIDTH'(32'h1000 + i);
      s_w_data[i] = DATA_WIDTH'(32'hA000 + i);
      s_r_addr[i] = ADDR_WIDTH'(32'h2000 + i);
    end
    tick(3);
    @(negedge clk);
    check("reset grant_id", 32'(grant_id), 32'(0));
    check("reset err_rsp", 32'(err_rsp), 32'(0));
    check("reset m_w_valid", 32'(m_w_valid), 32'(0));
    check("reset m_r_avalid", 32'(m_r_avalid), 32'(0));
    check("reset s_w_ready", 32'(s_w_ready), 32'(0));
    check("reset s_r_aready", 32'(s_r_aready), 32'(0));
    check("reset s_r_dvalid", 32'(s_r_dvalid), 32'(0));
    tick(1);
    reset_p = 1'b0;
    tick(1);

    // All three write continuously: one write every 2 cycles in grant order.
    for (int k = 0; k < 6; k++)
      gq.push_back(mk_g(1'b1, t1_ids[k], ADDR_WIDTH'(32'h1000 + t1_ids[k]),
                        DATA_WIDTH'(32'hA000 + t1_ids[k])));
    s_w_valid = '1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_w_hs("t1 write");
      if (k > 0) check("t1 write spacing", 32'(hs_cycle - prev), 32'(2));
      prev = hs_cycle;
    end
    s_w_valid = '0;
    drain("t1 drain");

    // Single read by requester 1, data returned 3 cycles after acceptance.
    gq.push_back(mk_g(1'b0, 1, 16'h0010, '0));
    rq.push_back(mk_r(1, 16'hBEEF));
    s_r_addr[1]   = 16'h0010;
    s_r_avalid[1] = 1'b1;
    wait_r_hs("t2 read");
    s_r_avalid[1] = 1'b0;
    tick(2);
    m_r_dvalid = 1'b1;
    m_r_data   = 16'hBEEF;
    tick(1);
    m_r_dvalid = 1'b0;
    drain("t2 drain");
    s_r_addr[1] = ADDR_WIDTH'(32'h2001);

    // Reads with no responses: ID FIFO fills, further reads stall, writes still pass.
    for (int k = 0; k < 4; k++)
      gq.push_back(mk_g(1'b0, t3_ids[k], ADDR_WIDTH'(32'h2000 + t3_ids[k]), '0));
    s_r_avalid = '1;
    for (int k = 0; k < 4; k++) wait_r_hs("t3 read");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3 full aready", 32'(s_r_aready), 32'(0));
      check("t3 full no read", 32'(m_r_avalid), 32'(0));
    end
    tick(1);
    gq.push_back(mk_g(1'b1, 0, 16'h1000, 16'hA000));
    s_w_valid[0] = 1'b1;
    wait_w_hs("t3 write");
    s_w_valid  = '0;
    s_r_avalid = '0;
    for (int k = 0; k < 4; k++) rq.push_back(mk_r(t3_ids[k], DATA_WIDTH'(32'h1111 * (k + 1))));
    for (int k = 0; k < 4; k++) begin
      m_r_dvalid = 1'b1;
      m_r_data   = DATA_WIDTH'(32'h1111 * (k + 1));
      tick(1);
    end
    m_r_dvalid = 1'b0;
    drain("t3 drain");

    // Requester 2 with both channels valid: write goes first.
    gq.push_back(mk_g(1'b1, 2, 16'h3002, 16'hC002));
    gq.push_back(mk_g(1'b0, 2, 16'h2002, '0));
    rq.push_back(mk_r(2, 16'h5A5A));
    s_w_addr[2]   = 16'h3002;
    s_w_data[2]   = 16'hC002;
    s_w_valid[2]  = 1'b1;
    s_r_avalid[2] = 1'b1;
    wait_w_hs("t4 write");
    s_w_valid[2] = 1'b0;
    wait_r_hs("t4 read");
    s_r_avalid[2] = 1'b0;
    m_r_dvalid = 1'b1;
    m_r_data   = 16'h5A5A;
    tick(1);
    m_r_dvalid = 1'b0;
    drain("t4 drain");
    s_w_addr[2] = 16'h1002;
    s_w_data[2] = 16'hA002;

    // Stray response sets the sticky error; reset mid-write clears everything.
    check("t5 err before", 32'(err_rsp), 32'(0));
    m_r_dvalid = 1'b1;
    m_r_data   = 16'hDEAD;
    @(negedge clk);
    check("t5 stray no dvalid", 32'(s_r_dvalid), 32'(0));
    tick(1);
    m_r_dvalid = 1'b0;
    tick(3);
    @(negedge clk);
    check("t5 err sticky", 32'(err_rsp), 32'(1));
    tick(1);
    m_w_ready    = 1'b0;
    s_w_addr[1]  = 16'h3001;
    s_w_data[1]  = 16'hC001;
    s_w_valid[1] = 1'b1;
    tick(2);
    @(negedge clk);
    check("t5 stalled m_w_valid", 32'(m_w_valid), 32'(1));
    check("t5 stalled grant_id", 32'(grant_id), 32'(1));
    reset_p = 1'b1;
    #1;
    check("t5 rst m_w_valid", 32'(m_w_valid), 32'(0));
    check("t5 rst s_w_ready", 32'(s_w_ready), 32'(0));
    check("t5 rst grant_id", 32'(grant_id), 32'(0));
    check("t5 rst err_rsp", 32'(err_rsp), 32'(0));
    check("t5 rst m_r_avalid", 32'(m_r_avalid), 32'(0));
    gq.push_back(mk_g(1'b1, 1, 16'h3001, 16'hC001));
    m_w_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_p = 1'b0;
    wait_w_hs("t5 write after reset");
    s_w_valid[1] = 1'b0;
    drain("t5 drain");
    s_w_addr[1] = 16'h1001;
    s_w_data[1] = 16'hA001;

    // Requesters 0 and 2 compete continuously.
    for (int k = 0; k < 4; k++)
      gq.push_back(mk_g(1'b1, t6_ids[k], ADDR_WIDTH'(32'h1000 + t6_ids[k]),
                        DATA_WIDTH'(32'hA000 + t6_ids[k])));
    s_w_valid[0] = 1'b1;
    s_w_valid[2] = 1'b1;
    for (int k = 0; k < 4; k++) wait_w_hs("t6 write");
    s_w_valid = '0;
    drain("t6 drain");
    check("final err_rsp", 32'(err_rsp), 32'(0));

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
